// File: rtl/rps4_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : rps4_req_queue
// Purpose  : Per-requester FIFOs feeding a 4-way rotating priority selector.
//            Pops the granted head and emits it, tagged with its channel id.
// Revision : 1.0 - initial release
// ============================================================================
module rps4_req_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            push,
    input  logic [4*DATA_W-1:0]   push_data,
    input  logic [3:0]            gnt,
    output logic [3:0]            req,
    output logic [3:0]            full,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_id,
    output logic [3:0]            overflow,
    output logic                  gnt_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;

    logic [3:0]          w_pop;
    logic                w_gnt_onehot;
    logic                w_gnt_err_now;
    logic [3:0]          w_ovf_now;
    logic [4*DATA_W-1:0] w_heads;
    logic [DATA_W-1:0]   w_sel_data;
    logic [1:0]          w_sel_id;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [1:0]          r_out_id;
    logic [3:0]          r_overflow;
    logic                r_gnt_err;

    // A pop needs a clean one-hot grant landing on a non-empty channel.
    assign w_gnt_onehot  = $onehot(gnt);
    assign w_pop         = w_gnt_onehot ? (gnt & req) : 4'b0000;
    assign w_gnt_err_now = (gnt != 4'b0000) &&
                           (!w_gnt_onehot || ((gnt & ~req) != 4'b0000));
    assign w_ovf_now     = push & full & ~w_pop;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [DATA_W-1:0]  r_mem [DEPTH];
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_OCC_W-1:0] r_occ;
        logic               w_push_ok;

        // req/full come from registered occupancy only, keeping the
        // selector loop free of combinational cycles.
        assign req[i]    = (r_occ != '0);
        assign full[i]   = (r_occ == c_OCC_W'(DEPTH));
        assign w_push_ok = push[i] & (~full[i] | w_pop[i]);
        assign w_heads[i*DATA_W +: DATA_W] = r_mem[r_rd_ptr];

        always_ff @(posedge clock) begin
            if (w_push_ok && !reset) begin
                r_mem[r_wr_ptr] <= push_data[i*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_occ    <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push_ok, w_pop[i]})
                    2'b10:   r_occ <= r_occ + 1'b1;
                    2'b01:   r_occ <= r_occ - 1'b1;
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_id   = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_pop[k]) begin
                w_sel_data = w_heads[k*DATA_W +: DATA_W];
                w_sel_id   = 2'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_overflow  <= '0;
            r_gnt_err   <= 1'b0;
        end else begin
            r_out_valid <= (w_pop != 4'b0000);
            if (w_pop != 4'b0000) begin
                r_out_data <= w_sel_data;
                r_out_id   <= w_sel_id;
            end
            r_overflow <= r_overflow | w_ovf_now;
            r_gnt_err  <= r_gnt_err | w_gnt_err_now;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign overflow  = r_overflow;
    assign gnt_err   = r_gnt_err;

endmodule
`default_nettype wire
